// File: rtl/apb_fir_acc_pkg.sv
// Shared definitions for the APB FIR accelerator: register offsets,
// CTRL/STATUS bit positions and the MAC engine state type.
package apb_fir_acc_pkg;

   // Register byte offsets
   localparam logic [11:0] OFF_CTRL       = 12'h000;
   localparam logic [11:0] OFF_STATUS     = 12'h004;
   localparam logic [11:0] OFF_DATA_IN    = 12'h008;
   localparam logic [11:0] OFF_DATA_OUT   = 12'h00C;
   localparam logic [11:0] OFF_SAMPLE_CNT = 12'h010;
   localparam logic [11:0] OFF_TAP0       = 12'h040;

   // CTRL fields
   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_CLR_BIT = 1;
   localparam int unsigned CTRL_NT_LSB  = 8;

   // STATUS fields
   localparam int unsigned STS_IN_EMPTY    = 0;
   localparam int unsigned STS_IN_FULL     = 1;
   localparam int unsigned STS_OUT_EMPTY   = 2;
   localparam int unsigned STS_OUT_FULL    = 3;
   localparam int unsigned STS_BUSY        = 4;
   localparam int unsigned STS_OVERFLOW    = 5;
   localparam int unsigned STS_UNDERFLOW   = 6;
   localparam int unsigned STS_IN_CNT_LSB  = 8;
   localparam int unsigned STS_OUT_CNT_LSB = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      WRITE = 2'd2
   } fir_state_e;

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with occupancy count and synchronous clear.
// Ports: clk/rst (sync, active-high), i_clear (flush), i_push/i_data (write),
//        i_pop/o_data (read head), o_full, o_empty, o_count.
// A push while full is accepted only if a pop happens on the same edge.
module fir_sync_fifo #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_clear,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd];

   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   // Pointer/count update; clear wins over any push/pop
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + AW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/apb_fir_acc.sv
// APB FIR accelerator: programmable taps, input/output sample FIFOs and a
// sequential single-multiplier MAC engine (IDLE -> MAC x ntaps -> WRITE).
// Ports: HCLK/HRESET (sync, active-high), APB slave PADDR/PWDATA/PWRITE/
//        PSEL/PENABLE in, PRDATA/PREADY/PSLVERR out (reads are combinational).
module apb_fir_acc
   import apb_fir_acc_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = 12,
   parameter int unsigned DW             = 12,
   parameter int unsigned TW             = 12,
   parameter int unsigned NTAPS          = 8,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR
);
   localparam int unsigned OW = DW + TW + $clog2(NTAPS);
   localparam int unsigned PW = DW + TW;
   localparam int unsigned IW = $clog2(NTAPS);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   if (OW > 32) begin : g_ow_too_wide
      $error("apb_fir_acc: accumulator width OW exceeds 32 bits");
   end

   fir_state_e             r_state;
   logic                   r_en;
   logic [7:0]             r_ntaps;
   logic [31:0]            r_cnt;
   logic                   r_ovf;
   logic                   r_udf;
   logic signed [OW-1:0]   r_acc;
   logic [IW-1:0]          r_idx;
   logic signed [TW-1:0]   r_tap   [NTAPS];
   logic signed [DW-1:0]   r_dline [NTAPS];

   logic                   w_access, w_wr, w_rd;
   logic [11:0]            w_addr, w_tap_off;
   logic                   w_sel_ctrl, w_sel_status, w_sel_din, w_sel_dout, w_sel_cnt, w_sel_tap;
   logic [IW-1:0]          w_tap_idx;
   logic [7:0]             w_nt_field, w_nt_wr;
   logic                   w_clear, w_start, w_in_push, w_out_pop, w_ovf_evt, w_udf_evt;
   logic [DW-1:0]          w_in_data;
   logic [OW-1:0]          w_out_data;
   logic                   w_in_full, w_in_empty, w_out_full, w_out_empty;
   logic [CW-1:0]          w_in_count, w_out_count;
   logic signed [PW-1:0]   w_prod;
   logic [31:0]            w_status, w_rdata;
   logic                   w_err;
   logic                   w_unused;

   assign w_unused = ^{PADDR[1:0], PWDATA[31:16]};

   // Address decode on the word index
   assign w_access     = PSEL & PENABLE;
   assign w_wr         = w_access & PWRITE;
   assign w_rd         = w_access & ~PWRITE;
   assign w_addr       = {PADDR[11:2], 2'b00};
   assign w_sel_ctrl   = (w_addr == OFF_CTRL);
   assign w_sel_status = (w_addr == OFF_STATUS);
   assign w_sel_din    = (w_addr == OFF_DATA_IN);
   assign w_sel_dout   = (w_addr == OFF_DATA_OUT);
   assign w_sel_cnt    = (w_addr == OFF_SAMPLE_CNT);
   assign w_sel_tap    = (w_addr >= OFF_TAP0) && (w_addr < OFF_TAP0 + 12'(4 * NTAPS));
   assign w_tap_off    = w_addr - OFF_TAP0;
   assign w_tap_idx    = w_tap_off[IW+1:2];

   // ntaps_active is clamped into 1..NTAPS on write
   assign w_nt_field = PWDATA[CTRL_NT_LSB +: 8];
   assign w_nt_wr    = (w_nt_field == 8'd0)        ? 8'd1 :
                       (w_nt_field > 8'(NTAPS))    ? 8'(NTAPS) : w_nt_field;

   // Edge events
   assign w_clear   = w_wr & w_sel_ctrl & PWDATA[CTRL_CLR_BIT];
   assign w_start   = (r_state == IDLE) & r_en & ~w_in_empty & ~w_out_full;
   assign w_in_push = w_wr & w_sel_din;
   assign w_ovf_evt = w_in_push & w_in_full & ~w_start;
   assign w_out_pop = w_rd & w_sel_dout;
   assign w_udf_evt = w_out_pop & w_out_empty;

   assign w_prod = PW'(r_tap[r_idx]) * PW'(r_dline[r_idx]);

   fir_sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_in_fifo (
      .clk     (HCLK),
      .rst     (HRESET),
      .i_clear (w_clear),
      .i_push  (w_in_push),
      .i_pop   (w_start),
      .i_data  (PWDATA[DW-1:0]),
      .o_data  (w_in_data),
      .o_full  (w_in_full),
      .o_empty (w_in_empty),
      .o_count (w_in_count)
   );

   fir_sync_fifo #(.WIDTH(OW), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk     (HCLK),
      .rst     (HRESET),
      .i_clear (w_clear),
      .i_push  (r_state == WRITE),
      .i_pop   (w_out_pop),
      .i_data  (r_acc),
      .o_data  (w_out_data),
      .o_full  (w_out_full),
      .o_empty (w_out_empty),
      .o_count (w_out_count)
   );

   // Control registers, tap file, delay line and MAC FSM
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state <= IDLE;
         r_en    <= 1'b0;
         r_ntaps <= 8'(NTAPS);
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
         r_acc   <= '0;
         r_idx   <= '0;
         for (int i = 0; i < NTAPS; i++) begin
            r_tap[i]   <= '0;
            r_dline[i] <= '0;
         end
      end else if (w_clear) begin
         // Like reset, but taps and ntaps_active survive
         r_state <= IDLE;
         r_en    <= 1'b0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
         r_acc   <= '0;
         r_idx   <= '0;
         for (int i = 0; i < NTAPS; i++) r_dline[i] <= '0;
      end else begin
         if (w_wr && w_sel_ctrl) begin
            r_en    <= PWDATA[CTRL_EN_BIT];
            r_ntaps <= w_nt_wr;
         end
         if (w_wr && w_sel_tap && !r_en) r_tap[w_tap_idx] <= PWDATA[TW-1:0];
         if (w_ovf_evt) r_ovf <= 1'b1;
         if (w_udf_evt) r_udf <= 1'b1;

         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_dline[0] <= w_in_data;
                  for (int i = 1; i < NTAPS; i++) r_dline[i] <= r_dline[i-1];
                  r_acc   <= '0;
                  r_idx   <= '0;
                  r_state <= MAC;
               end
            end
            MAC: begin
               r_acc <= r_acc + OW'(w_prod);
               r_idx <= r_idx + IW'(1);
               // >= keeps the engine bounded if ntaps shrinks mid-sample
               if (8'(r_idx) >= r_ntaps - 8'd1) r_state <= WRITE;
            end
            WRITE: begin
               r_cnt   <= r_cnt + 32'd1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // STATUS word from current (pre-edge) state
   always_comb begin
      w_status                            = '0;
      w_status[STS_IN_EMPTY]              = w_in_empty;
      w_status[STS_IN_FULL]               = w_in_full;
      w_status[STS_OUT_EMPTY]             = w_out_empty;
      w_status[STS_OUT_FULL]              = w_out_full;
      w_status[STS_BUSY]                  = (r_state != IDLE);
      w_status[STS_OVERFLOW]              = r_ovf;
      w_status[STS_UNDERFLOW]             = r_udf;
      w_status[STS_IN_CNT_LSB +: 8]       = 8'(w_in_count);
      w_status[STS_OUT_CNT_LSB +: 8]      = 8'(w_out_count);
   end

   // Read mux and error response
   always_comb begin
      w_rdata = '0;
      w_err   = 1'b0;
      if (w_access) begin
         if (w_sel_ctrl) begin
            if (!PWRITE) begin
               w_rdata[CTRL_EN_BIT]       = r_en;
               w_rdata[CTRL_NT_LSB +: 8]  = r_ntaps;
            end
         end else if (w_sel_status) begin
            if (PWRITE) w_err = 1'b1;
            else        w_rdata = w_status;
         end else if (w_sel_din) begin
            w_rdata = '0;
         end else if (w_sel_dout) begin
            if (PWRITE)            w_err = 1'b1;
            else if (!w_out_empty) w_rdata = 32'($signed(w_out_data));
         end else if (w_sel_cnt) begin
            if (PWRITE) w_err = 1'b1;
            else        w_rdata = r_cnt;
         end else if (w_sel_tap) begin
            if (!PWRITE) w_rdata = 32'(r_tap[w_tap_idx]);
         end else begin
            w_err = 1'b1;
         end
      end
   end

   assign PRDATA  = w_rdata & {32{w_rd}};
   assign PSLVERR = w_err;
   assign PREADY  = 1'b1;

endmodule

// File: doc/apb_fir_acc.md
# apb_fir_acc

Second-generation APB FIR accelerator for the PULPino peripheral bus. It adds runtime-programmable taps, a programmable active tap count, input and output sample FIFOs, and a sequential single-multiplier MAC engine. Software can stream samples and collect results without lock-step polling. It sits as an APB slave in the peripheral subsystem, in the same slot class as the other 4 KB APB peripherals.

## Interface
- APB_ADDR_WIDTH, 12: APB address width (4 KB slave).
- DW, 12: signed sample width; sample = PWDATA[DW-1:0].
- TW, 12: signed tap width; tap = PWDATA[TW-1:0].
- NTAPS, 8: maximum tap count, also the delay-line length.
- FIFO_DEPTH, 4: depth of the input FIFO and of the output FIFO (power of 2).
- OW, DW+TW+$clog2(NTAPS): signed accumulator width; must be ≤32 (elaboration assertion).
- HCLK in 1: clock. Reset is synchronous and active-high.
- HRESET in 1: synchronous active-high reset.
- PADDR in APB_ADDR_WIDTH: byte address; the word index is PADDR[11:2].
- PWDATA in 32: write data.
- PWRITE in 1: write strobe.
- PSEL in 1: slave select.
- PENABLE in 1: access phase.
- PRDATA out 32: read data.
- PREADY out 1: tied to 1; no wait states.
- PSLVERR out 1: error response.

## Operation
- An access is any edge with PSEL&PENABLE.
- Register map (byte offset):
  - 0x00 CTRL: [0] enable; [1] clear (write-1 pulse, reads 0); [15:8] ntaps_active. A write of 0 is stored as 1, and a write >NTAPS is stored as NTAPS.
  - 0x04 STATUS (RO): [0] in_empty; [1] in_full; [2] out_empty; [3] out_full; [4] busy; [5] overflow (sticky); [6] underflow (sticky); [15:8] in_count; [23:16] out_count.
  - 0x08 DATA_IN (WO): a write pushes a sample to the input FIFO. If the FIFO is full and not popped that edge, the write is dropped and overflow is set.
  - 0x0C DATA_OUT (RO): a read pops the output FIFO and returns the result sign-extended to 32 bits. A read when empty returns 0 and sets underflow.
  - 0x10 SAMPLE_CNT (RO): 32-bit count of results produced; wraps at 2^32.
  - 0x40+4*i TAP[i] (RW), i<NTAPS: written only while enable=0; otherwise the write is ignored.
- PSLVERR=1 during the access phase to any unmapped offset, and on a write to a RO register. Write data is discarded in both cases.
- PRDATA=0 when no read access is in progress.
- MAC FSM:
  - IDLE: if enable, input FIFO not empty and output FIFO not full, then pop the sample, shift it into dline[0] (dline[i] moves to dline[i+1]), set acc=0 and idx=0, and go to MAC.
  - MAC: acc += tap[idx]*dline[idx] (signed, full precision, sign-extended to OW), then idx++. When idx==ntaps_active-1, go to WRITE.
  - WRITE: push acc into the output FIFO, increment SAMPLE_CNT, go to IDLE.
  - busy = (state≠IDLE).
- Result definition: y[n] = Σ_{i<ntaps_active} tap[i]·x[n−i], with x taken as 0 before the first sample or clear.
- Clear: same edge effect as HRESET, except that taps and CTRL.ntaps_active are retained. CTRL.enable is cleared.
- Simultaneous events on one edge:
  - DATA_IN push with FSM pop: both occur.
  - DATA_OUT pop with FSM push: both occur and the count is unchanged.
  - Clear has priority over all other events.
- Dropping enable mid-computation finishes the current sample; the FSM then stays in IDLE.

## Timing
- Reset values: PRDATA=0, PREADY=1, PSLVERR=0.
- Reset state: FSM in IDLE, FIFOs empty, dline=0, taps=0, enable=0, ntaps_active=NTAPS, SAMPLE_CNT=0, sticky flags=0.
- Reset asserted mid-computation aborts the computation; no result is pushed.
- Latency: with the FSM idle and the output FIFO not full, a DATA_IN write accepted at edge t is popped at t+1. The result is pushed at edge t+ntaps_active+2, so out_empty reads 0 from then on.
- Throughput is one result per ntaps_active+2 cycles.
- Register reads are combinational from current state. STATUS reflects the state before the current edge.

## Structure
- Package apb_fir_acc_pkg holds:
  - register offset localparams;
  - CTRL/STATUS bit positions;
  - the FSM state enum typedef (IDLE, MAC, WRITE).
- Sub-module fir_sync_fifo (params WIDTH, DEPTH; ports push, pop, data, full, empty, count), instantiated twice: WIDTH=DW for input, WIDTH=OW for output.
- The tap register file, delay line, MAC datapath and FSM live in the top module.

## Test plan
- Impulse: TAP[0..2]=1,2,3, ntaps_active=3, enable=1, write samples 1,0,0,0 → DATA_OUT reads 1,2,3,0; SAMPLE_CNT=4.
- Signed arithmetic: TAP[0]=0xFFF (−1), ntaps_active=1, sample 0x800 (−2048) → DATA_OUT=0x00000800.
- Overflow: enable=0, write 5 samples → STATUS in_full=1, in_count=4, overflow=1. Then enable=1 → exactly 4 results.
- Latency: ntaps_active=8, single write at edge t → out_empty falls at t+10. Read of an empty DATA_OUT → returns 0 and underflow=1.
- Clear mid-MAC: write a sample, pulse clear 3 cycles later → no result produced; FIFOs empty; TAP values unchanged on readback.
- Protocol: TAP write with enable=1 → ignored. Access to 0x20 → PSLVERR=1, PRDATA=0. Write to STATUS → PSLVERR=1.
